// File: rtl/iris_sched_pkg.sv
// Shared types and widths for the iris-centre scheduler: eye encoding,
// scheduler states and the packed result word held in the result FIFO.
package iris_sched_pkg;

   localparam int ANG_W = 12;
   localparam int RE_W  = 13;
   localparam int POS_W = 14;
   localparam int RES_W = 29;

   localparam logic EYE_LEFT  = 1'b0;
   localparam logic EYE_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic             eye;
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
   } iris_res_t;

endpackage

// File: rtl/iris_center_sched_if.sv
// Bundle of the two eye request channels, the shared datapath operand/result
// wires and the result stream. master = environment side, slave = scheduler.
interface iris_center_sched_if;
   import iris_sched_pkg::*;

   logic             l_valid, l_ready, r_valid, r_ready;
   logic [ANG_W-1:0] l_theta, l_phi, r_theta, r_phi;
   logic [RE_W-1:0]  l_rE, r_rE;
   logic [POS_W-1:0] l_x, l_y, r_x, r_y;

   logic [ANG_W-1:0] dp_theta, dp_phi;
   logic [RE_W-1:0]  dp_rE;
   logic [POS_W-1:0] dp_x, dp_y, dp_iris_x, dp_iris_y;

   logic             res_valid, res_ready, res_eye;
   logic [POS_W-1:0] res_x, res_y;

   modport master (
      output l_valid, l_theta, l_phi, l_rE, l_x, l_y,
      output r_valid, r_theta, r_phi, r_rE, r_x, r_y,
      input  l_ready, r_ready,
      input  dp_theta, dp_phi, dp_rE, dp_x, dp_y,
      output dp_iris_x, dp_iris_y,
      input  res_valid, res_eye, res_x, res_y,
      output res_ready
   );

   modport slave (
      input  l_valid, l_theta, l_phi, l_rE, l_x, l_y,
      input  r_valid, r_theta, r_phi, r_rE, r_x, r_y,
      output l_ready, r_ready,
      output dp_theta, dp_phi, dp_rE, dp_x, dp_y,
      input  dp_iris_x, dp_iris_y,
      output res_valid, res_eye, res_x, res_y,
      input  res_ready
   );

endinterface

// File: rtl/iris_sched_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; dout reads as zero when
// empty so the result outputs stay quiet after reset.
module iris_sched_fifo #(
   parameter int WIDTH = 29,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             full, do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/iris_center_sched.sv
// Round-robin scheduler sharing one iris-centre datapath between both eyes.
// Define IRIS_SCHED_STATS_EN to add issue/stall statistics counters.
module iris_center_sched
   import iris_sched_pkg::*;
#(
   parameter int PIPE_LAT   = 9,
   parameter int FIFO_DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic flush,
   output logic flush_done,
   output logic busy,
`ifdef IRIS_SCHED_STATS_EN
   input  logic        stats_clr,
   output logic [15:0] l_issue_cnt,
   output logic [15:0] r_issue_cnt,
   output logic [15:0] stall_cnt,
`endif
   iris_center_sched_if.slave bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   sched_state_t state;
   logic         last_grant, grant_eye, issue, credit, any_valid, capture, pop, fifo_empty;
   logic [CW-1:0] inflight, fifo_count;
   logic [CW:0]   used;
   logic [1:0]    tag [PIPE_LAT+1];
   iris_res_t     push_data, head;

   // Credits count both in-flight work and queued results so a capture never finds the FIFO full.
   assign any_valid = bus.l_valid || bus.r_valid;
   assign used      = {1'b0, inflight} + {1'b0, fifo_count};
   assign credit    = used < (CW+1)'(FIFO_DEPTH);
   assign issue     = (state == RUN) && en && !flush && any_valid && credit;
   assign grant_eye = bus.r_valid && (!bus.l_valid || last_grant == EYE_LEFT);
   assign bus.l_ready = issue && (grant_eye == EYE_LEFT);
   assign bus.r_ready = issue && (grant_eye == EYE_RIGHT);

   assign capture   = tag[PIPE_LAT][1];
   assign push_data = '{eye: tag[PIPE_LAT][0], x: bus.dp_iris_x, y: bus.dp_iris_y};
   assign pop       = !fifo_empty && bus.res_ready;
   assign busy      = (state != IDLE) || (inflight != '0) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         flush_done   <= 1'b0;
         last_grant   <= EYE_RIGHT;
         inflight     <= '0;
         bus.dp_theta <= '0;
         bus.dp_phi   <= '0;
         bus.dp_rE    <= '0;
         bus.dp_x     <= '0;
         bus.dp_y     <= '0;
         for (int k = 0; k <= PIPE_LAT; k++) tag[k] <= 2'b00;
      end else begin
         flush_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (flush)   flush_done <= 1'b1;
               else if (en) state      <= RUN;
            end
            RUN: begin
               if (flush || !en) state <= DRAIN;
            end
            DRAIN: begin
               if (inflight == '0 && fifo_empty) begin
                  flush_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (issue) begin
            last_grant   <= grant_eye;
            bus.dp_theta <= grant_eye ? bus.r_theta : bus.l_theta;
            bus.dp_phi   <= grant_eye ? bus.r_phi   : bus.l_phi;
            bus.dp_rE    <= grant_eye ? bus.r_rE    : bus.l_rE;
            bus.dp_x     <= grant_eye ? bus.r_x     : bus.l_x;
            bus.dp_y     <= grant_eye ? bus.r_y     : bus.l_y;
         end

         // Tag pipe lines up with the datapath so tag[PIPE_LAT] marks a valid dp_iris_* result.
         tag[0] <= issue ? {1'b1, grant_eye} : 2'b00;
         for (int k = 1; k <= PIPE_LAT; k++) tag[k] <= tag[k-1];

         unique case ({issue, capture})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: ;
         endcase
      end
   end

   iris_sched_fifo #(
      .WIDTH (RES_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (capture),
      .din   (push_data),
      .pop   (pop),
      .dout  (head),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.res_valid = !fifo_empty;
   assign bus.res_eye   = head.eye;
   assign bus.res_x     = head.x;
   assign bus.res_y     = head.y;

`ifdef IRIS_SCHED_STATS_EN
   // Saturating counters; clear has priority over any increment in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst || stats_clr) begin
         l_issue_cnt <= '0;
         r_issue_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if (issue && grant_eye == EYE_LEFT && l_issue_cnt != 16'hFFFF)
            l_issue_cnt <= l_issue_cnt + 16'd1;
         if (issue && grant_eye == EYE_RIGHT && r_issue_cnt != 16'hFFFF)
            r_issue_cnt <= r_issue_cnt + 16'd1;
         if (state == RUN && any_valid && !credit && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_iris_center_sched.sv
// Directed bench for iris_center_sched with a behavioural fixed-latency datapath.
// Exercises the IRIS_SCHED_STATS_EN counters when that macro is defined.
module tb_iris_center_sched;
   import iris_sched_pkg::*;

   localparam int PIPE_LAT   = 9;
   localparam int FIFO_DEPTH = 16;

   logic clk = 1'b0;
   logic rst, en, flush, flush_done, busy;
`ifdef IRIS_SCHED_STATS_EN
   logic        stats_clr;
   logic [15:0] l_issue_cnt, r_issue_cnt, stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int k, hs, both, bad, npop, nfd, s3, fdc;

   iris_center_sched_if bus();

   always #5 clk = ~clk;

   // Datapath stand-in: x + rE/8 + theta[3:0], y - rE/16 - phi[3:0], PIPE_LAT cycles after dp_* change.
   logic [POS_W-1:0] mdl_x [PIPE_LAT];
   logic [POS_W-1:0] mdl_y [PIPE_LAT];
   always @(posedge clk) begin
      mdl_x[0] <= bus.dp_x + POS_W'(bus.dp_rE >> 3) + POS_W'(bus.dp_theta[3:0]);
      mdl_y[0] <= bus.dp_y - POS_W'(bus.dp_rE >> 4) - POS_W'(bus.dp_phi[3:0]);
      for (int i = 1; i < PIPE_LAT; i++) begin
         mdl_x[i] <= mdl_x[i-1];
         mdl_y[i] <= mdl_y[i-1];
      end
   end
   assign bus.dp_iris_x = mdl_x[PIPE_LAT-1];
   assign bus.dp_iris_y = mdl_y[PIPE_LAT-1];

   iris_center_sched #(
      .PIPE_LAT   (PIPE_LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .flush       (flush),
      .flush_done  (flush_done),
      .busy        (busy),
`ifdef IRIS_SCHED_STATS_EN
      .stats_clr   (stats_clr),
      .l_issue_cnt (l_issue_cnt),
      .r_issue_cnt (r_issue_cnt),
      .stall_cnt   (stall_cnt),
`endif
      .bus         (bus)
   );

   task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic eye, input logic [11:0] theta, input logic [11:0] phi,
                                input logic [12:0] re, input logic [13:0] x, input logic [13:0] y);
      if (eye == EYE_LEFT) begin
         bus.l_theta = theta; bus.l_phi = phi; bus.l_rE = re; bus.l_x = x; bus.l_y = y;
      end else begin
         bus.r_theta = theta; bus.r_phi = phi; bus.r_rE = re; bus.r_x = x; bus.r_y = y;
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic waitRes(input int budget);
      int n = 0;
      while (!bus.res_valid && n < budget) begin
         nextCycle(); settle(); n++;
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; flush = 1'b0;
`ifdef IRIS_SCHED_STATS_EN
      stats_clr = 1'b0;
`endif
      bus.l_valid = 1'b0; bus.r_valid = 1'b0; bus.res_ready = 1'b0;
      applyStimulus(EYE_LEFT, '0, '0, '0, '0, '0);
      applyStimulus(EYE_RIGHT, '0, '0, '0, '0, '0);
      nextCycle(); nextCycle(); settle();
      checkOutput("rst res_valid", 32'(bus.res_valid), 0);
      checkOutput("rst busy", 32'(busy), 0);
      checkOutput("rst l_ready", 32'(bus.l_ready), 0);
      checkOutput("rst flush_done", 32'(flush_done), 0);
      checkOutput("rst dp_theta", 32'(bus.dp_theta), 0);
      checkOutput("rst dp_x", 32'(bus.dp_x), 0);
      checkOutput("rst res_x", 32'(bus.res_x), 0);

      $display("[TB] test 1: single left request");
      nextCycle(); rst = 1'b1; en = 1'b1; settle();
      nextCycle();
      applyStimulus(EYE_LEFT, 12'h100, 12'h200, 13'h0A0, 14'd100, 14'd200);
      bus.l_valid = 1'b1; settle();
      checkOutput("t1 l_ready", 32'(bus.l_ready), 1);
      checkOutput("t1 r_ready", 32'(bus.r_ready), 0);
      nextCycle(); bus.l_valid = 1'b0; settle(); k = 1;
      checkOutput("t1 dp_theta", 32'(bus.dp_theta), 32'h100);
      checkOutput("t1 dp_rE", 32'(bus.dp_rE), 32'h0A0);
      while (!bus.res_valid && k < 30) begin nextCycle(); settle(); k++; end
      checkOutput("t1 latency", 32'(k), 11);
      checkOutput("t1 res_eye", 32'(bus.res_eye), 0);
      checkOutput("t1 res_x", 32'(bus.res_x), 120);
      checkOutput("t1 res_y", 32'(bus.res_y), 190);
      checkOutput("t1 dp_x held", 32'(bus.dp_x), 100);
      nextCycle(); bus.res_ready = 1'b1; settle();
      nextCycle(); bus.res_ready = 1'b0; settle();
      checkOutput("t1 popped", 32'(bus.res_valid), 0);

      $display("[TB] test 2: alternating grants");
      nextCycle(); rst = 1'b0; settle();
      nextCycle(); rst = 1'b1; settle();
      applyStimulus(EYE_LEFT, 12'h003, 12'h001, 13'h080, 14'd1000, 14'd2000);
      applyStimulus(EYE_RIGHT, 12'h005, 12'h002, 13'h040, 14'd3000, 14'd500);
      bus.res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nextCycle(); bus.l_valid = 1'b1; bus.r_valid = 1'b1; settle();
         checkOutput($sformatf("t2 l_ready %0d", i), 32'(bus.l_ready), (i % 2 == 0) ? 1 : 0);
         checkOutput($sformatf("t2 r_ready %0d", i), 32'(bus.r_ready), (i % 2 == 1) ? 1 : 0);
      end
      nextCycle(); bus.l_valid = 1'b0; bus.r_valid = 1'b0; settle();
      for (int i = 0; i < 4; i++) begin
         waitRes(30);
         checkOutput($sformatf("t2 res_valid %0d", i), 32'(bus.res_valid), 1);
         checkOutput($sformatf("t2 res_eye %0d", i), 32'(bus.res_eye), i % 2);
         checkOutput($sformatf("t2 res_x %0d", i), 32'(bus.res_x), (i % 2 == 1) ? 3013 : 1019);
         checkOutput($sformatf("t2 res_y %0d", i), 32'(bus.res_y), (i % 2 == 1) ? 494 : 1991);
         nextCycle(); settle();
      end
      checkOutput("t2 drained", 32'(bus.res_valid), 0);

      $display("[TB] test 3: credit exhaustion");
      bus.res_ready = 1'b0; hs = 0; both = 0;
      for (int c = 0; c < 40; c++) begin
         nextCycle(); bus.l_valid = 1'b1; bus.r_valid = 1'b1; settle();
         if (bus.l_ready && bus.r_ready) both++;
         if (bus.l_ready || bus.r_ready) hs++;
      end
      checkOutput("t3 handshakes", 32'(hs), FIFO_DEPTH);
      checkOutput("t3 dual ready", 32'(both), 0);
      nextCycle(); bus.res_ready = 1'b1; settle();
      checkOutput("t3 no ready before pop", 32'(bus.l_ready || bus.r_ready), 0);
      nextCycle(); bus.res_ready = 1'b0; settle();
      checkOutput("t3 credit after pop", 32'(bus.l_ready || bus.r_ready), 1);
      nextCycle(); settle();
      checkOutput("t3 single credit", 32'(bus.l_ready || bus.r_ready), 0);
      nextCycle(); bus.l_valid = 1'b0; bus.r_valid = 1'b0; bus.res_ready = 1'b1; settle();
      npop = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.res_valid) npop++;
         nextCycle(); settle();
      end
      checkOutput("t3 drained count", 32'(npop), FIFO_DEPTH);
      checkOutput("t3 drained", 32'(bus.res_valid), 0);

      $display("[TB] test 4: flush with work in flight");
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         applyStimulus(EYE_LEFT, 12'h000, 12'h000, 13'h080, 14'(10 * (i + 1)), 14'd50);
         bus.l_valid = 1'b1; settle();
         checkOutput($sformatf("t4 l_ready %0d", i), 32'(bus.l_ready), 1);
      end
      nextCycle(); flush = 1'b1;
      applyStimulus(EYE_LEFT, 12'h000, 12'h000, 13'h080, 14'd40, 14'd50); settle();
      checkOutput("t4 flush blocks", 32'(bus.l_ready), 0);
      npop = 0; nfd = 0; bad = 0; s3 = -100; fdc = -1;
      for (int c = 0; c < 40; c++) begin
         nextCycle(); flush = 1'b0; en = 1'b0; settle();
         if (bus.l_ready || bus.r_ready) bad++;
         if (bus.res_valid) begin
            checkOutput($sformatf("t4 res_x %0d", npop), 32'(bus.res_x), 26 + 10 * npop);
            npop++;
            if (npop == 3) s3 = c;
         end
         if (flush_done) begin
            nfd++;
            fdc = c;
            checkOutput("t4 busy at done", 32'(busy), 0);
         end
      end
      bus.l_valid = 1'b0;
      checkOutput("t4 readys in drain", 32'(bad), 0);
      checkOutput("t4 results", 32'(npop), 3);
      checkOutput("t4 flush_done pulses", 32'(nfd), 1);
      checkOutput("t4 flush_done timing", 32'(fdc), 32'(s3 + 2));
      checkOutput("t4 idle busy", 32'(busy), 0);
      nextCycle(); flush = 1'b1; settle();
      nextCycle(); flush = 1'b0; settle();
      checkOutput("idle flush_done", 32'(flush_done), 1);
      nextCycle(); settle();
      checkOutput("idle flush_done pulse", 32'(flush_done), 0);

      $display("[TB] test 5: reset discards in-flight work");
      nextCycle(); en = 1'b1; settle();
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         applyStimulus(EYE_LEFT, 12'h000, 12'h000, 13'h0A0, 14'(1000 + i), 14'd100);
         bus.l_valid = 1'b1; settle();
         checkOutput($sformatf("t5 l_ready %0d", i), 32'(bus.l_ready), 1);
      end
      nextCycle(); bus.l_valid = 1'b0; rst = 1'b0; settle();
      nextCycle(); rst = 1'b1; settle();
      checkOutput("t5 busy after rst", 32'(busy), 0);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         nextCycle(); settle();
         if (bus.res_valid) bad++;
      end
      checkOutput("t5 stale results", 32'(bad), 0);
      nextCycle();
      applyStimulus(EYE_LEFT, 12'h000, 12'h000, 13'h0A0, 14'd500, 14'd600);
      bus.l_valid = 1'b1; settle();
      checkOutput("t5 post-rst ready", 32'(bus.l_ready), 1);
      nextCycle(); bus.l_valid = 1'b0; settle();
      waitRes(30);
      checkOutput("t5 res_valid", 32'(bus.res_valid), 1);
      checkOutput("t5 res_eye", 32'(bus.res_eye), 0);
      checkOutput("t5 res_x", 32'(bus.res_x), 520);
      checkOutput("t5 res_y", 32'(bus.res_y), 590);

`ifdef IRIS_SCHED_STATS_EN
      $display("[TB] test 6: statistics counters");
      nextCycle(); bus.res_ready = 1'b0; settle();
      for (int i = 0; i < 11; i++) begin
         nextCycle(); bus.l_valid = 1'b1; settle();
      end
      nextCycle(); bus.l_valid = 1'b0; stats_clr = 1'b1; settle();
      nextCycle(); stats_clr = 1'b0; settle();
      checkOutput("t6 cleared l", 32'(l_issue_cnt), 0);
      for (int i = 0; i < 3; i++) begin
         nextCycle(); bus.l_valid = 1'b1; bus.r_valid = 1'b0; settle();
         checkOutput($sformatf("t6 l_ready %0d", i), 32'(bus.l_ready), 1);
      end
      for (int i = 0; i < 2; i++) begin
         nextCycle(); bus.l_valid = 1'b0; bus.r_valid = 1'b1; settle();
         checkOutput($sformatf("t6 r_ready %0d", i), 32'(bus.r_ready), 1);
      end
      for (int i = 0; i < 4; i++) begin
         nextCycle(); bus.l_valid = 1'b1; bus.r_valid = 1'b1; settle();
         checkOutput($sformatf("t6 stalled %0d", i), 32'(bus.l_ready || bus.r_ready), 0);
      end
      nextCycle(); bus.l_valid = 1'b0; bus.r_valid = 1'b0; settle();
      checkOutput("t6 l_issue_cnt", 32'(l_issue_cnt), 3);
      checkOutput("t6 r_issue_cnt", 32'(r_issue_cnt), 2);
      checkOutput("t6 stall_cnt", 32'(stall_cnt), 4);
      nextCycle(); stats_clr = 1'b1; settle();
      nextCycle(); stats_clr = 1'b0; settle();
      checkOutput("t6 clr l", 32'(l_issue_cnt), 0);
      checkOutput("t6 clr r", 32'(r_issue_cnt), 0);
      checkOutput("t6 clr stall", 32'(stall_cnt), 0);
      bus.res_ready = 1'b1;
      repeat (40) begin nextCycle(); settle(); end
      checkOutput("t6 drained", 32'(bus.res_valid), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
